// File: rtl/sub_operand_sequencer.sv
// Operand sequencer for an external subtractor: captures a minuend and a
// subtrahend from switches on successive button presses, then registers the
// returned difference together with borrow and an absolute magnitude.
module sub_operand_sequencer #(
    parameter int DATA_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load_btn,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    input  logic [DATA_WIDTH-1:0] result_in,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  borrow,
    output logic [DATA_WIDTH-1:0] magnitude,
    output logic                  valid,
    output logic [1:0]            state_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HAVE_A = 2'b01,
        CALC   = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t state;
    state_t next_state;

    logic sync1;
    logic sync2;
    logic sync3;
    logic load_pulse;

    logic load_a;
    logic load_b;
    logic capture;
    logic drop_valid;

    // Absolute difference of two unsigned operands; never wraps.
    function automatic logic [DATA_WIDTH-1:0] abs_diff(
        input logic [DATA_WIDTH-1:0] x,
        input logic [DATA_WIDTH-1:0] y
    );
        if (y > x) begin
            return y - x;
        end
        return x - y;
    endfunction

    // Button synchronizer plus edge-detect delay flop; clear does not touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= load_btn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // One-cycle pulse per button rise; a held button yields a single pulse.
    assign load_pulse = sync2 & ~sync3;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath enables; clear overrides any pending pulse.
    always_comb begin
        next_state = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        capture    = 1'b0;
        drop_valid = 1'b0;
        if (clear) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_pulse) begin
                        load_a     = 1'b1;
                        next_state = HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (load_pulse) begin
                        load_b     = 1'b1;
                        next_state = CALC;
                    end
                end
                CALC: begin
                    // A pulse landing here is deliberately dropped.
                    capture    = 1'b1;
                    next_state = DONE;
                end
                DONE: begin
                    if (load_pulse) begin
                        load_a     = 1'b1;
                        drop_valid = 1'b1;
                        next_state = HAVE_A;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out      <= '0;
            b_out      <= '0;
            result_out <= '0;
            borrow     <= 1'b0;
            magnitude  <= '0;
            valid      <= 1'b0;
        end else if (clear) begin
            a_out      <= '0;
            b_out      <= '0;
            result_out <= '0;
            borrow     <= 1'b0;
            magnitude  <= '0;
            valid      <= 1'b0;
        end else begin
            if (load_a) begin
                a_out <= data_in;
            end
            if (load_b) begin
                b_out <= data_in;
            end
            if (drop_valid) begin
                valid <= 1'b0;
            end
            if (capture) begin
                result_out <= result_in;
                borrow     <= (b_out > a_out);
                magnitude  <= abs_diff(a_out, b_out);
                valid      <= 1'b1;
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_sub_operand_sequencer.sv
// Directed bench for sub_operand_sequencer with an external subtractor model
// and a scoreboard of expected completed results.
module tb_sub_operand_sequencer;

    localparam int W = 5;

    logic         clk;
    logic         rst;
    logic [W-1:0] data_in;
    logic         load_btn;
    logic         clear;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic [W-1:0] result_in;
    logic [W-1:0] result_out;
    logic         borrow;
    logic [W-1:0] magnitude;
    logic         valid;
    logic [1:0]   state_out;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    typedef struct {
        int a;
        int b;
        int res;
        int brw;
        int mag;
    } exp_t;

    exp_t sb[$];

    sub_operand_sequencer #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_btn   (load_btn),
        .clear      (clear),
        .a_out      (a_out),
        .b_out      (b_out),
        .result_in  (result_in),
        .result_out (result_out),
        .borrow     (borrow),
        .magnitude  (magnitude),
        .valid      (valid),
        .state_out  (state_out)
    );

    // Downstream subtractor: plain modulo-2^W difference.
    assign result_in = a_out - b_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, a_out, 0);
        check({tag, "_b"}, b_out, 0);
        check({tag, "_res"}, result_out, 0);
        check({tag, "_borrow"}, borrow, 0);
        check({tag, "_mag"}, magnitude, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_state"}, state_out, 0);
    endtask

    // Raise the button and wait for the load edge (third edge after the rise).
    task automatic press_start(input int d);
        data_in  = W'(d);
        load_btn = 1'b1;
        repeat (3) tick();
    endtask

    // Drop the button long enough to re-arm the edge detector.
    task automatic release_btn();
        load_btn = 1'b0;
        repeat (2) tick();
    endtask

    task automatic load_a(input int d);
        press_start(d);
        check("load_a_state", state_out, 1);
        check("load_a_val", a_out, d);
        release_btn();
    endtask

    // Load the subtrahend, record the expected result and check the CALC timing.
    task automatic load_b(input int a, input int b);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.res = (a - b + 32) % 32;
        e.brw = (b > a) ? 1 : 0;
        e.mag = (a >= b) ? (a - b) : (b - a);
        sb.push_back(e);
        press_start(b);
        check("calc_state", state_out, 2);
        check("calc_valid", valid, 0);
        tick();
        check("done_state", state_out, 3);
        check("done_valid", valid, 1);
        load_btn = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: pop and compare on each rising valid.
    always @(posedge clk) begin : monitor
        static logic vq = 1'b0;
        exp_t e;
        #1;
        if (valid === 1'b1 && vq !== 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                pops++;
                check("sb_a", a_out, e.a);
                check("sb_b", b_out, e.b);
                check("sb_result", result_out, e.res);
                check("sb_borrow", borrow, e.brw);
                check("sb_magnitude", magnitude, e.mag);
            end
        end
        vq = valid;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        data_in  = '0;
        load_btn = 1'b0;
        clear    = 1'b0;
        repeat (2) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // First load with edge-accurate timing, then b = 4.
        data_in  = 5'd9;
        load_btn = 1'b1;
        tick();
        check("sync_e1_state", state_out, 0);
        tick();
        check("sync_e2_state", state_out, 0);
        tick();
        check("sync_e3_state", state_out, 1);
        check("sync_e3_a", a_out, 9);
        release_btn();
        load_b(9, 4);
        check("done_hold_state", state_out, 3);
        check("done_hold_valid", valid, 1);

        // Reload from DONE: valid drops, b keeps its old value.
        press_start(31);
        check("reload_valid", valid, 0);
        check("reload_a", a_out, 31);
        check("reload_state", state_out, 1);
        check("reload_b_kept", b_out, 4);
        release_btn();
        load_b(31, 2);

        // Clear from DONE.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_zero("clear");

        // Wrapping difference with borrow.
        load_a(3);
        load_b(3, 5);

        // Held button loads exactly once.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        data_in  = 5'd11;
        load_btn = 1'b1;
        repeat (20) tick();
        check("hold_state", state_out, 1);
        check("hold_a", a_out, 11);
        check("hold_b", b_out, 0);
        release_btn();

        // Clear coinciding with a load pulse in HAVE_A.
        data_in  = 5'd17;
        load_btn = 1'b1;
        repeat (2) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_pulse_state", state_out, 0);
        check("clr_pulse_a", a_out, 0);
        check("clr_pulse_b", b_out, 0);
        check("clr_pulse_valid", valid, 0);
        tick();
        check("clr_pulse_not_queued", state_out, 0);
        release_btn();

        // Asynchronous reset mid-cycle while in HAVE_A.
        load_a(12);
        @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check("async_rst_a", a_out, 0);
        check("async_rst_state", state_out, 0);
        #2;
        rst = 1'b0;
        tick();
        check("post_rst_state", state_out, 0);
        load_a(7);
        load_b(7, 7);

        // Button held across reset release gives one load afterwards.
        @(posedge clk);
        #1;
        rst      = 1'b1;
        data_in  = 5'd21;
        load_btn = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("held_rst_state", state_out, 1);
        check("held_rst_a", a_out, 21);
        repeat (5) tick();
        check("held_rst_once", state_out, 1);
        release_btn();

        repeat (2) tick();
        check("sb_all_popped", pops, 4);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
